// File: rtl/hazard_control_unit.sv
// DOF-stage hazard sequencer: write scoreboard, RAW stall/bubble, taken-branch flush FSM, event counters.
// Optional macro BYPASS_EN: forward from EX/WB instead of stalling on non-load hits.
module hazard_control_unit #(
    parameter int ADDR_BITS      = 5,
    parameter int PIPE_DEPTH     = 2,
    parameter int BRANCH_PENALTY = 2,
    parameter int CNT_BITS       = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [ADDR_BITS-1:0] AA,
    input  logic [ADDR_BITS-1:0] BA,
    input  logic                 a_used,
    input  logic                 b_used,
    input  logic                 dof_rw,
    input  logic [ADDR_BITS-1:0] dof_da,
    input  logic                 dof_load,
    input  logic                 branch_taken,
    output logic                 stall,
    output logic                 bubble,
    output logic                 flush,
    output logic [1:0]           fwd_a,
    output logic [1:0]           fwd_b,
    output logic [CNT_BITS-1:0]  stall_cnt,
    output logic [CNT_BITS-1:0]  flush_cnt
);
    localparam logic [2:0] PEN_M1 = 3'(BRANCH_PENALTY - 1);

    typedef enum logic {S_RUN, S_FLUSH} state_t;

    state_t                 state;
    logic [2:0]             fcnt;
    logic                   sb_valid [PIPE_DEPTH];
    logic [ADDR_BITS-1:0]   sb_da    [PIPE_DEPTH];
    logic                   hit_a;
    logic                   hit_b;
    logic                   need_a;
    logic                   need_b;
    logic                   accept;

    // Outputs are gated by reset so an asynchronous reset silences them at once.
    assign flush  = !reset && (branch_taken || state == S_FLUSH);
    assign stall  = !reset && (need_a || need_b) && !flush;
    assign bubble = stall || flush;
    assign accept = !stall && !flush;

`ifdef BYPASS_EN
    logic       sb_load [PIPE_DEPTH];
    logic [1:0] idx_a;
    logic [1:0] idx_b;
    logic       ld_a;
    logic       ld_b;

    // Scan oldest to youngest so the youngest matching entry is the one kept.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        idx_a = 2'd0;
        idx_b = 2'd0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        for (int i = PIPE_DEPTH - 1; i >= 0; i--) begin
            if (a_used && AA != '0 && sb_valid[i] && sb_da[i] == AA) begin
                hit_a = 1'b1;
                idx_a = 2'(i);
                ld_a  = sb_load[i];
            end
            if (b_used && BA != '0 && sb_valid[i] && sb_da[i] == BA) begin
                hit_b = 1'b1;
                idx_b = 2'(i);
                ld_b  = sb_load[i];
            end
        end
    end

    // Only a load still in EX has no value to forward yet.
    assign need_a = hit_a && idx_a == 2'd0 && ld_a;
    assign need_b = hit_b && idx_b == 2'd0 && ld_b;
    assign fwd_a  = (hit_a && !need_a && idx_a < 2'd2) ? idx_a + 2'd1 : 2'd0;
    assign fwd_b  = (hit_b && !need_b && idx_b < 2'd2) ? idx_b + 2'd1 : 2'd0;
`else
    logic unused_load;

    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        for (int i = 0; i < PIPE_DEPTH; i++) begin
            if (a_used && AA != '0 && sb_valid[i] && sb_da[i] == AA) hit_a = 1'b1;
            if (b_used && BA != '0 && sb_valid[i] && sb_da[i] == BA) hit_b = 1'b1;
        end
    end

    assign need_a      = hit_a;
    assign need_b      = hit_b;
    assign fwd_a       = 2'd0;
    assign fwd_b       = 2'd0;
    assign unused_load = dof_load;
`endif

    // Scoreboard: entry 0 is EX; stalled or flushed instructions enter as invalid.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PIPE_DEPTH; i++) begin
                sb_valid[i] <= 1'b0;
                sb_da[i]    <= '0;
`ifdef BYPASS_EN
                sb_load[i]  <= 1'b0;
`endif
            end
        end else begin
            for (int i = PIPE_DEPTH - 1; i > 0; i--) begin
                sb_valid[i] <= sb_valid[i-1];
                sb_da[i]    <= sb_da[i-1];
`ifdef BYPASS_EN
                sb_load[i]  <= sb_load[i-1];
`endif
            end
            sb_valid[0] <= accept && dof_rw && dof_da != '0;
            sb_da[0]    <= dof_da;
`ifdef BYPASS_EN
            sb_load[0]  <= dof_load;
`endif
        end
    end

    // fcnt holds the flush cycles still owed after the current one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_RUN;
            fcnt  <= 3'd0;
        end else begin
            case (state)
                S_RUN: begin
                    if (branch_taken && PEN_M1 != 3'd0) begin
                        state <= S_FLUSH;
                        fcnt  <= PEN_M1;
                    end
                end
                S_FLUSH: begin
                    if (branch_taken) begin
                        fcnt <= PEN_M1;
                    end else if (fcnt <= 3'd1) begin
                        state <= S_RUN;
                        fcnt  <= 3'd0;
                    end else begin
                        fcnt <= fcnt - 3'd1;
                    end
                end
                default: begin
                    state <= S_RUN;
                    fcnt  <= 3'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
            if (flush && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
        end
    end
endmodule
